filter_frame_ctrl: RTL and testbench

Frame-level sequencer for the line-buffered Ope_Size x Ope_Size filter unit. It gates the input pixel stream into one frame and pulses the filter's reflesh at frame start. It tracks pixel column/row and flags which filter outputs come from a window fully inside the image, delayed to match the operation pipeline. The filter datapath has no clock enable, so the block requires gap-free delivery and aborts on underrun.

---
 rtl/filter_frame_ctrl_if.sv | 38 +++
 rtl/filter_frame_ctrl.sv | 176 +++++++++++++++++
 tb/tb_filter_frame_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/filter_frame_ctrl_if.sv
// Control/stream bundle between a pixel source and filter_frame_ctrl.
// Optional macro FRAME_CNT_EN adds the frame_count field.
interface filter_frame_ctrl_if;
    logic        start;
    logic [31:0] image_width;
    logic [31:0] image_height;
    logic        pix_valid;
    logic        pix_ready;
    logic        reflesh;
    logic        busy;
    logic        out_valid;
    logic [9:0]  out_col;
    logic [9:0]  out_row;
    logic        frame_done;
    logic        err_size;
    logic        err_underrun;
`ifdef FRAME_CNT_EN
    logic [15:0] frame_count;
`endif

    modport master (
        output start, image_width, image_height, pix_valid,
        input  pix_ready, reflesh, busy, out_valid, out_col, out_row,
               frame_done, err_size, err_underrun
`ifdef FRAME_CNT_EN
        , input frame_count
`endif
    );

    modport slave (
        input  start, image_width, image_height, pix_valid,
        output pix_ready, reflesh, busy, out_valid, out_col, out_row,
               frame_done, err_size, err_underrun
`ifdef FRAME_CNT_EN
        , output frame_count
`endif
    );
endinterface

// File: rtl/filter_frame_ctrl.sv
// Frame sequencer for the line-buffered OPE_SIZE x OPE_SIZE filter: gates one frame,
// pulses reflesh, tags full-window outputs. Optional macro FRAME_CNT_EN adds frame_count.
module filter_frame_ctrl #(
    parameter int OPE_SIZE    = 3,
    parameter int OPE_LATENCY = 2,
    parameter int MAX_WIDTH   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    filter_frame_ctrl_if.slave   bus
);
    localparam int HALF = (OPE_SIZE - 1) / 2;
    localparam int FW   = (OPE_LATENCY > 1) ? $clog2(OPE_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REFRESH,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_width;
    logic [31:0] r_height;
    logic [9:0]  r_col;
    logic [9:0]  r_row;
    logic [FW-1:0] r_flush_cnt;

    logic r_pv [OPE_LATENCY];
    logic [9:0] r_pc [OPE_LATENCY];
    logic [9:0] r_pr [OPE_LATENCY];

    logic w_size_ok;
    logic w_accept;
    logic w_underrun;
    logic w_last_col;
    logic w_last_row;
    logic w_win;
    logic [9:0] w_tag_col;
    logic [9:0] w_tag_row;
    logic w_pix_ready;
    logic w_reflesh;
    logic w_err_size;
    logic w_err_underrun;
    logic w_frame_done;

    assign w_size_ok = (bus.image_width  >= 32'(OPE_SIZE)) && (bus.image_width  <= 32'(MAX_WIDTH)) &&
                       (bus.image_height >= 32'(OPE_SIZE)) && (bus.image_height <= 32'(MAX_WIDTH));
    assign w_accept   = (r_state == S_RUN) &&  bus.pix_valid;
    assign w_underrun = (r_state == S_RUN) && !bus.pix_valid;
    // Compare in 32 bits so an oversized latch can never alias onto the 10-bit counters.
    assign w_last_col = ({22'd0, r_col} == (r_width  - 32'd1));
    assign w_last_row = ({22'd0, r_row} == (r_height - 32'd1));
    assign w_win      = w_accept && (r_row >= 10'(OPE_SIZE - 1)) && (r_col >= 10'(OPE_SIZE - 1));
    assign w_tag_col  = r_col - 10'(HALF);
    assign w_tag_row  = r_row - 10'(HALF);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_pix_ready    = 1'b0;
        w_reflesh      = 1'b0;
        w_err_size     = 1'b0;
        w_err_underrun = 1'b0;
        w_frame_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (w_size_ok) w_state_next = S_REFRESH;
                    else           w_err_size   = 1'b1;
                end
            end
            S_REFRESH: begin
                w_reflesh    = 1'b1;
                w_state_next = S_RUN;
            end
            S_RUN: begin
                w_pix_ready = 1'b1;
                if (bus.pix_valid) begin
                    if (w_last_col && w_last_row) w_state_next = S_FLUSH;
                end else begin
                    // The filter has no clock enable, so a gap corrupts its line buffers: abort.
                    w_err_underrun = 1'b1;
                    w_reflesh      = 1'b1;
                    w_state_next   = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (r_flush_cnt == FW'(OPE_LATENCY - 1)) w_state_next = S_DONE;
            end
            S_DONE: begin
                w_frame_done = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_width     <= 32'd0;
            r_height    <= 32'd0;
            r_col       <= 10'd0;
            r_row       <= 10'd0;
            r_flush_cnt <= '0;
        end else begin
            if ((r_state == S_IDLE) && bus.start && w_size_ok) begin
                r_width  <= bus.image_width;
                r_height <= bus.image_height;
            end
            if (r_state == S_REFRESH) begin
                r_col <= 10'd0;
                r_row <= 10'd0;
            end else if (w_accept) begin
                if (w_last_col) begin
                    r_col <= 10'd0;
                    r_row <= r_row + 10'd1;
                end else begin
                    r_col <= r_col + 10'd1;
                end
            end
            if (r_state == S_FLUSH) r_flush_cnt <= r_flush_cnt + 1'b1;
            else                    r_flush_cnt <= '0;
        end
    end

    // Tag pipeline aligns the full-window flag with the operation stage's data_out.
    always_ff @(posedge clk) begin
        if (rst || w_underrun) begin
            for (int i = 0; i < OPE_LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_pc[i] <= 10'd0;
                r_pr[i] <= 10'd0;
            end
        end else begin
            for (int i = OPE_LATENCY - 1; i > 0; i--) begin
                r_pv[i] <= r_pv[i-1];
                r_pc[i] <= r_pc[i-1];
                r_pr[i] <= r_pr[i-1];
            end
            r_pv[0] <= w_win;
            r_pc[0] <= w_tag_col;
            r_pr[0] <= w_tag_row;
        end
    end

    assign bus.pix_ready    = w_pix_ready;
    assign bus.reflesh      = w_reflesh;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.out_valid    = r_pv[OPE_LATENCY-1];
    assign bus.out_col      = r_pc[OPE_LATENCY-1];
    assign bus.out_row      = r_pr[OPE_LATENCY-1];
    assign bus.frame_done   = w_frame_done;
    assign bus.err_size     = w_err_size;
    assign bus.err_underrun = w_err_underrun;

`ifdef FRAME_CNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge clk) begin
        if (rst)                    r_frame_count <= 16'd0;
        else if (r_state == S_DONE) r_frame_count <= r_frame_count + 16'd1;
    end

    assign bus.frame_count = r_frame_count;
`endif
endmodule

// File: tb/tb_filter_frame_ctrl.sv
// Randomized self-checking bench for filter_frame_ctrl against a frame-level scoreboard.
module tb_filter_frame_ctrl;
    localparam int S    = 3;
    localparam int L    = 2;
    localparam int MW   = 1024;
    localparam int HALF = (S - 1) / 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    filter_frame_ctrl_if bus();

    filter_frame_ctrl #(
        .OPE_SIZE    (S),
        .OPE_LATENCY (L),
        .MAX_WIDTH   (MW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int cyc;
        int col;
        int row;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks     = 0;
    int   n_fail       = 0;
    int   cyc          = 0;
    int   exp_done_cyc = -1;
    int   n_out        = 0;

    logic       s_pix_ready, s_reflesh, s_busy, s_out_valid, s_frame_done;
    logic       s_err_size, s_err_underrun;
    logic [9:0] s_out_col, s_out_row;
`ifdef FRAME_CNT_EN
    logic [15:0] s_frame_count;
    int          exp_fc = 0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    // One clock: sample at negedge, score out_valid/frame_done against the model, advance.
    task automatic tick();
        bit exp_v;
        @(negedge clk);
        s_pix_ready    = bus.pix_ready;
        s_reflesh      = bus.reflesh;
        s_busy         = bus.busy;
        s_out_valid    = bus.out_valid;
        s_out_col      = bus.out_col;
        s_out_row      = bus.out_row;
        s_frame_done   = bus.frame_done;
        s_err_size     = bus.err_size;
        s_err_underrun = bus.err_underrun;
        exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        check("out_valid", s_out_valid, exp_v);
        if (exp_v) begin
            if (s_out_valid) begin
                check("out_col", s_out_col, exp_q[0].col);
                check("out_row", s_out_row, exp_q[0].row);
                n_out++;
            end
            void'(exp_q.pop_front());
        end
        check("frame_done", s_frame_done, cyc == exp_done_cyc);
`ifdef FRAME_CNT_EN
        s_frame_count = bus.frame_count;
        check("frame_count", s_frame_count, exp_fc);
        if (s_frame_done) exp_fc = (exp_fc + 1) % 65536;
`endif
        $display("cyc=%0d busy=%0b rdy=%0b vld=%0b ov=%0b col=%0d row=%0d done=%0b",
                 cyc, s_busy, s_pix_ready, bus.pix_valid, s_out_valid, s_out_col, s_out_row, s_frame_done);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic bad_start(input int w, input int h);
        bus.start        = 1'b1;
        bus.image_width  = w;
        bus.image_height = h;
        tick();
        check("err_size_pulse", s_err_size, 1);
        check("err_size_busy", s_busy, 0);
        check("err_size_reflesh", s_reflesh, 0);
        bus.start = 1'b0;
        tick();
        check("err_size_once", s_err_size, 0);
        check("err_size_busy2", s_busy, 0);
        check("err_size_reflesh2", s_reflesh, 0);
    endtask

    // Runs one frame; drop>=0 withholds that pixel, abort_flush asserts rst during FLUSH.
    task automatic run_frame(input int w, input int h, input int drop, input bit hold, input bit abort_flush);
        int  npix;
        bit  seen;
        npix = w * h;
        bus.start        = 1'b1;
        bus.image_width  = w;
        bus.image_height = h;
        bus.pix_valid    = 1'b0;
        tick();
        check("start_idle_busy", s_busy, 0);
        check("start_err_size", s_err_size, 0);
        if (!hold) bus.start = 1'b0;
        tick();
        check("refresh_pulse", s_reflesh, 1);
        check("refresh_busy", s_busy, 1);
        check("refresh_ready", s_pix_ready, 0);
        n_out = 0;
        for (int p = 0; p < npix; p++) begin
            if (p == drop) begin
                bus.pix_valid = 1'b0;
                tick();
                check("underrun_err", s_err_underrun, 1);
                check("underrun_reflesh", s_reflesh, 1);
                exp_q.delete();
                tick();
                check("underrun_idle", s_busy, 0);
                check("underrun_once", s_err_underrun, 0);
                return;
            end
            bus.pix_valid = 1'b1;
            if ((p / w) >= S - 1 && (p % w) >= S - 1)
                exp_q.push_back('{cyc + L, (p % w) - HALF, (p / w) - HALF});
            if (p == npix - 1) exp_done_cyc = cyc + L + 1;
            tick();
            check("pix_ready_run", s_pix_ready, 1);
        end
        bus.pix_valid = 1'b0;
        if (abort_flush) begin
            tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            exp_q.delete();
            exp_done_cyc = -1;
`ifdef FRAME_CNT_EN
            exp_fc = 0;
`endif
            tick();
            check("rst_busy", s_busy, 0);
            check("rst_ready", s_pix_ready, 0);
            check("rst_reflesh", s_reflesh, 0);
            check("rst_err_underrun", s_err_underrun, 0);
            check("rst_out_col", s_out_col, 0);
            check("rst_out_row", s_out_row, 0);
            return;
        end
        seen = 1'b0;
        for (int g = 0; g < 4 * L + 8 && !seen; g++) begin
            tick();
            if (s_frame_done) seen = 1'b1;
            else check("flush_ready", s_pix_ready, 0);
        end
        check("frame_done_seen", seen, 1);
        check("n_out", n_out, (w - S + 1) * (h - S + 1));
    endtask

    initial begin
        int w, h, d;
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.image_width  = 32'd0;
        bus.image_height = 32'd0;
        bus.pix_valid    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("reset_busy", s_busy, 0);
        check("reset_ready", s_pix_ready, 0);
        check("reset_reflesh", s_reflesh, 0);
        check("reset_err_size", s_err_size, 0);
        check("reset_err_underrun", s_err_underrun, 0);
        check("reset_out_col", s_out_col, 0);

        run_frame(8, 4, -1, 1'b0, 1'b0);
        bad_start(2, 4);
        bad_start(1025, 4);
        run_frame(8, 4, 10, 1'b0, 1'b0);
        run_frame(8, 4, -1, 1'b0, 1'b1);
        run_frame(8, 4, -1, 1'b0, 1'b0);

        run_frame(3, 3, -1, 1'b1, 1'b0);
        run_frame(3, 3, -1, 1'b1, 1'b0);
        bus.start = 1'b0;
        tick();
        check("held_start_idle", s_busy, 0);
        tick();
        check("held_start_no_refresh", s_reflesh, 0);

        run_frame(1024, 3, -1, 1'b0, 1'b0);

        repeat (10) begin
            w = $urandom_range(3, 40);
            h = $urandom_range(3, 12);
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, w * h - 1)) : -1;
            run_frame(w, h, d, 1'b0, 1'b0);
        end
        tick();
        check("final_idle", s_busy, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
